// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline latches: state encoding
// for the skid-buffered stage and the payload layout used to pack DATA_W.
package pipe_pkg;

    // Skid stage occupancy: EMPTY (nothing held), FULL (main valid),
    // SKID (main and skid both valid).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    // Payload field widths: IR32 + PC32 + R1 32 + Rd5 + ctl5.
    localparam int unsigned IR_W  = 32;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned R1_W  = 32;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CTL_W = 5;

    // Field offsets, LSB first: ctl, rd, r1, pc, ir.
    localparam int unsigned CTL_OFF = 0;
    localparam int unsigned RD_OFF  = CTL_OFF + CTL_W;
    localparam int unsigned R1_OFF  = RD_OFF + RD_W;
    localparam int unsigned PC_OFF  = R1_OFF + R1_W;
    localparam int unsigned IR_OFF  = PC_OFF + PC_W;

    localparam int unsigned PAYLOAD_W = IR_OFF + IR_W;  // 106

    // Packs the stage fields into one flat payload word.
    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic [IR_W-1:0]  ir,
        input logic [PC_W-1:0]  pc,
        input logic [R1_W-1:0]  r1,
        input logic [RD_W-1:0]  rd,
        input logic [CTL_W-1:0] ctl
    );
        return {ir, pc, r1, rd, ctl};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Count up on inc until the all-ones ceiling, then hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid
// buffer. Both handshake outputs and out_data come straight from flops.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = 106,
    parameter int unsigned ZERO_BUBBLE = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Occupancy FSM with registered handshake flags and the two data regs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            if (ZERO_BUBBLE != 0) begin
                main_q <= '0;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state       <= ST_FULL;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer) begin
                        state      <= ST_SKID;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state       <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        if (ZERO_BUBBLE != 0) begin
                            main_q <= '0;
                        end
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state      <= ST_FULL;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    main_q      <= '0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    // main_q is cleared on every entry to EMPTY when ZERO_BUBBLE is set,
    // so it can drive out_data directly without a gating mux.
    assign out_data  = main_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid_q & ~out_ready),
        .q   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic, all
// checked against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 106;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;
    logic          in_ready_s;
    logic          out_valid_s;
    logic [DW-1:0] out_data_s;
    logic [3:0]    stall_cnt_s;

    int unsigned total = 0;
    int unsigned bad = 0;

    logic [DW-1:0] mq[$];   // items held by the stage, oldest first
    logic [DW-1:0] dq[$];   // items delivered downstream
    int unsigned   ms16;
    int unsigned   ms4;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .ZERO_BUBBLE(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    // Second instance with a narrow counter, driven identically.
    pipe_stage_skid #(.DATA_W(DW), .ZERO_BUBBLE(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .stall_cnt(stall_cnt_s)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ms16 = 0;
        ms4 = 0;
    endtask

    // One clock of the reference: a FIFO of depth 2 with flush.
    task automatic model_update();
        bit ov;
        bit ir;
        if (!rst) begin
            model_reset();
            return;
        end
        ov = (mq.size() > 0);
        ir = (mq.size() < 2);
        if (ov && !out_ready) begin
            if (ms16 < 65535) ms16++;
            if (ms4 < 15) ms4++;
        end
        if (ov && out_ready) dq.push_back(mq.pop_front());
        if (flush) mq.delete();
        else if (in_valid && ir) mq.push_back(in_data);
    endtask

    task automatic check_all();
        logic [DW-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, mq.size() < 2);
        chk("out_data", out_data, exp_data);
        chk("stall_cnt", stall_cnt, ms16);
        chk("stall_cnt_w4", stall_cnt_s, ms4);
        chk("out_valid_w4", out_valid_s, mq.size() > 0);
        chk("out_data_w4", out_data_s, exp_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        dq.delete();
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    initial begin
        bit seen55;
        model_reset();

        // 1. Reset holds the stage empty even with traffic offered.
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 106'hABC;
        out_ready = 1'b1;
        tick();
        tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_data", out_data, '0);
        chk("reset_stall", stall_cnt, '0);

        // Release reset together with flush: first edge must flush, dropping 0xABC.
        #1;
        rst = 1'b1;
        flush = 1'b1;
        tick();
        chk("rel_flush_out_valid", out_valid, 1'b0);
        flush = 1'b0;
        in_valid = 1'b0;

        // 2. Streaming 1..8 back to back at full throughput.
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data = DW'(k);
            tick();
            chk("stream_data", out_data, k);
            chk("stream_in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_count", dq.size(), 8);
        for (int k = 0; k < 8; k++) chk("stream_order", dq[k], k + 1);

        // 3. Backpressure fills the skid entry, then drains in order.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'(1);
        tick();
        in_data = DW'(2);
        tick();
        chk("bp_in_ready_skid", in_ready, 1'b0);
        in_data = DW'(3);
        tick();
        tick();
        chk("bp_head_held", out_data, 1);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("bp_stall_cnt", stall_cnt, 3);
        chk("bp_count", dq.size(), 3);
        for (int k = 0; k < 3; k++) chk("bp_order", dq[k], k + 1);

        // 4. Flush in SKID while 0x55 is offered.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'(16'hA1);
        tick();
        in_data = DW'(16'hA2);
        tick();
        flush = 1'b1;
        in_data = DW'(8'h55);
        tick();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_data", out_data, '0);
        chk("flush_in_ready", in_ready, 1'b1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        seen55 = 1'b0;
        foreach (dq[i]) if (dq[i] == DW'(8'h55)) seen55 = 1'b1;
        chk("flush_no_55", seen55, 1'b0);

        // 5. Narrow counter saturates at 15 and holds.
        do_reset();
        in_valid = 1'b1;
        in_data = DW'(7);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("sat_w4", stall_cnt_s, 4'd15);
        chk("sat_w16", stall_cnt, 20);
        tick();
        chk("sat_w4_hold", stall_cnt_s, 4'd15);

        // 6. Asynchronous reset in mid-cycle while FULL.
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data = DW'(16'hBEEF);
        tick();
        chk("pre_async_full", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_out_data", out_data, '0);
        chk("async_in_ready", in_ready, 1'b1);
        chk("async_stall", stall_cnt, '0);
        #1;
        rst = 1'b1;
        dq.delete();
        for (int k = 0; k < 4; k++) begin
            in_data = DW'(100 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("recover_count", dq.size(), 4);
        for (int k = 0; k < 4; k++) chk("recover_order", dq[k], 100 + k);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 29) == 0);
            in_data = rnd_data();
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
